// File: rtl/series_pkg.sv
// Purpose : shared constants, FSM state type and sign-extension helper for the Horner series evaluator.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package series_pkg;

    localparam int DATA_W  = 16;          // x, coefficients, x2, acc, result
    localparam int FRAC    = 10;          // fractional bits of x/x2/acc/result
    localparam int CFRAC   = 10;          // fractional bits of a ROM coefficient
    localparam int N_TERMS = 7;           // ROM entries walked, N_TERMS-1 .. 0
    localparam int PROD_W  = 2 * DATA_W;  // full-precision product width

    localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(1 << FRAC);
    localparam logic [2:0]               LAST_IDX = 3'(N_TERMS - 1);
    localparam logic [2:0]               IDLE_SEL = 3'd7;  // ROM entry 7 reads as 0

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        ITER
    } state_t;

    // Sign-extend a DATA_W operand to product width so multiplies keep every bit.
    function automatic logic signed [PROD_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

endpackage

// File: rtl/series_eval_fsm_if.sv
// Purpose : start/busy/done handshake, operand/result and ROM address/data bundle of the series evaluator.
// Latency : n/a (wiring only).
// Backpressure : none; start is only honoured while the evaluator is idle.
// Ports: start, x_in (controller -> evaluator); busy, done, result (evaluator -> controller);
//        rom_select (evaluator -> ROM); rom_coef (ROM -> evaluator, combinational from rom_select).
interface series_eval_fsm_if;
    import series_pkg::*;

    logic                     start;
    logic signed [DATA_W-1:0] x_in;
    logic [2:0]               rom_select;
    logic signed [DATA_W-1:0] rom_coef;
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] result;

    // Controller / ROM side
    modport master (
        output start, x_in, rom_coef,
        input  rom_select, busy, done, result
    );

    // Evaluator side
    modport slave (
        input  start, x_in, rom_coef,
        output rom_select, busy, done, result
    );

endinterface

// File: rtl/sat_reduce.sv
// Purpose : reduce a PROD_W signed value to DATA_W, saturating when SERIES_EVAL_SAT_EN is defined, else wrapping.
// Latency : combinational.
// Backpressure : n/a.
// Ports: din_i (PROD_W signed in), dout_o (DATA_W signed out). Macro: SERIES_EVAL_SAT_EN.
module sat_reduce
    import series_pkg::*;
(
    input  logic signed [PROD_W-1:0] din_i,
    output logic signed [DATA_W-1:0] dout_o
);

`ifdef SERIES_EVAL_SAT_EN
    // The value fits when every bit from the DATA_W sign position upward agrees.
    logic fits;
    assign fits = (&din_i[PROD_W-1:DATA_W-1]) | ~(|din_i[PROD_W-1:DATA_W-1]);

    always_comb begin
        dout_o = din_i[DATA_W-1:0];
        if (!fits) begin
            dout_o = din_i[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    // Two's-complement wrap: the upper half is simply discarded.
    logic unused_hi;
    assign unused_hi = ^din_i[PROD_W-1:DATA_W];
    assign dout_o    = din_i[DATA_W-1:0];
`endif

endmodule

// File: rtl/series_eval_fsm.sv
// Purpose : Horner-scheme series evaluator: latches x, forms x2, walks ROM 6..0 with acc <- ONE + p*acc.
// Latency : start accepted at edge E -> done pulse registered at edge E+9; back-to-back restart in the done cycle.
// Backpressure : start ignored while busy (no queueing); optional saturation via SERIES_EVAL_SAT_EN.
// Ports: clk, rst_n (sync, active-low); bus (slave modport: start, x_in, rom_coef in;
//        rom_select, busy, done, result out).
module series_eval_fsm
    import series_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    series_eval_fsm_if.slave bus
);

    state_t                   state_q, state_d;
    logic                     sq_ph_q, sq_ph_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] x2_q, x2_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] result_q, result_d;
    logic [2:0]               sel_q, sel_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] sq_prod, sq_shift;
    logic signed [PROD_W-1:0] p_prod, p_shift;
    logic signed [PROD_W-1:0] mac_prod, acc_sum;
    logic signed [DATA_W-1:0] x2_red, p_red, acc_red;

    assign sq_prod  = sext(x_q) * sext(x_q);
    assign sq_shift = sq_prod >>> FRAC;

    assign p_prod   = sext(bus.rom_coef) * sext(x2_q);
    assign p_shift  = p_prod >>> CFRAC;

    // p is reduced to DATA_W before it meets acc.
    assign mac_prod = sext(p_red) * sext(acc_q);
    assign acc_sum  = sext(ONE) + (mac_prod >>> FRAC);

    sat_reduce u_x2_red  (.din_i(sq_shift), .dout_o(x2_red));
    sat_reduce u_p_red   (.din_i(p_shift),  .dout_o(p_red));
    sat_reduce u_acc_red (.din_i(acc_sum),  .dout_o(acc_red));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sq_ph_q  <= 1'b0;
            x_q      <= '0;
            x2_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sel_q    <= IDLE_SEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sq_ph_q  <= sq_ph_d;
            x_q      <= x_d;
            x2_q     <= x2_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sq_ph_d  = sq_ph_q;
        x_d      = x_q;
        x2_d     = x2_q;
        acc_d    = acc_q;
        result_d = result_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;             // done is a single-cycle pulse

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x_in;
                    busy_d  = 1'b1;
                    sq_ph_d = 1'b0;
                    state_d = SQUARE;
                end
            end

            // SQUARE spends two cycles: x2 is registered first, then acc and
            // the ROM address are primed, so the square multiplier never sits
            // in the same combinational path as the coefficient MAC.
            SQUARE: begin
                if (!sq_ph_q) begin
                    x2_d    = x2_red;
                    sq_ph_d = 1'b1;
                end else begin
                    acc_d   = ONE;
                    sel_d   = LAST_IDX;
                    sq_ph_d = 1'b0;
                    state_d = ITER;
                end
            end

            ITER: begin
                acc_d = acc_red;
                if (sel_q != 3'd0) begin
                    sel_d = sel_q - 3'd1;
                end else begin
                    result_d = acc_red;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    sel_d    = IDLE_SEL;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rom_select = sel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;

endmodule

// File: tb/tb_series_eval_fsm.sv
// Purpose : self-checking bench for series_eval_fsm against a timing/arithmetic reference model.
// Latency : n/a.
// Backpressure : n/a. Model follows SERIES_EVAL_SAT_EN the same way the design does.
module tb_series_eval_fsm;
    import series_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    series_eval_fsm_if bus ();

    series_eval_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Coefficient ROM: cosine-style Horner terms, -1/((2k+1)(2k+2)) in Q10; entry 7 is 0.
    logic signed [15:0] rom [8];
    assign bus.rom_coef = rom[bus.rom_select];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic signed [15:0] red(input longint v);
`ifdef SERIES_EVAL_SAT_EN
        if (v > 64'sd32767)  return 16'sh7FFF;
        if (v < -64'sd32768) return 16'sh8000;
`endif
        return v[15:0];
    endfunction

    // Full evaluation: x2 plus acc after every step (accs[0] = ONE, accs[7] = result).
    task automatic golden(input logic signed [15:0] x, output logic signed [15:0] x2,
                          output logic signed [15:0] accs [8]);
        longint xl, p, acc;
        xl  = x;
        x2  = red((xl * xl) >>> 10);
        acc = 1024;
        accs[0] = 16'sd1024;
        for (int k = 6; k >= 0; k--) begin
            p   = red((longint'(rom[k]) * longint'(x2)) >>> 10);
            acc = red(1024 + ((p * acc) >>> 10));
            accs[7-k] = acc[15:0];
        end
    endtask

    // ---------------- cycle-level expectation ----------------
    // m_k counts edges since the accepting edge; an operation ends at m_k == 9.
    bit                 m_busy = 1'b0;
    bit                 m_done = 1'b0;
    int                 m_k = 0;
    logic signed [15:0] m_res = '0;
    logic signed [15:0] m_x2 = '0;
    logic signed [15:0] m_accs [8];
    int                 m_done_cnt = 0;
    int                 dut_done_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
            m_res  = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_k++;
                if (m_k == 9) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_accs[7];
                    m_done_cnt++;
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_k    = 0;
                golden(bus.x_in, m_x2, m_accs);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       bus.busy,       m_busy);
            chk("done",       bus.done,       m_done);
            chk("result",     bus.result,     m_res);
            chk("rom_select", bus.rom_select, (m_busy && m_k >= 2) ? 8 - m_k : 7);
            if (m_busy && m_k >= 1) chk("x2", dut.x2_q, m_x2);
            if (m_busy && m_k >= 2)  chk("acc_step", dut.acc_q, m_accs[m_k-2]);
            else if (m_done)         chk("acc_final", dut.acc_q, m_accs[7]);
            if (bus.done) dut_done_cnt++;
        end
    end

    // One operation with a single-cycle start; returns done latency (-1 on timeout).
    int sel_seen [10];
    task automatic run_op(input logic signed [15:0] x, output int lat, output logic signed [15:0] res);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.x_in = x;
        @(posedge clk);              // accepting edge E
        #1 bus.start = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k < 10) sel_seen[k] = int'(bus.rom_select);
            if (bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int                 lat;
        int                 c0;
        int                 cyc;
        logic signed [15:0] res, gx2;
        logic signed [15:0] gaccs [8];

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.x_in   = '0;
        rom[0] = -16'sd512; rom[1] = -16'sd85; rom[2] = -16'sd34; rom[3] = -16'sd18;
        rom[4] = -16'sd11;  rom[5] = -16'sd8;  rom[6] = -16'sd6;  rom[7] = 16'sd0;

        // Pin the reference model with hand-worked values.
        golden(16'sd0, gx2, gaccs);
        chk("model_x0_result", gaccs[7], 1024);
        golden(16'sd32, gx2, gaccs);
        chk("model_x32_x2", gx2, 1);
        chk("model_x32_step1", gaccs[1], 1023);
        chk("model_x32_result", gaccs[7], 1023);
        golden(16'sh7FFF, gx2, gaccs);
`ifdef SERIES_EVAL_SAT_EN
        chk("model_7fff_x2", gx2, 32767);
`else
        chk("model_7fff_x2", gx2, -64);   // 16'hFFC0
`endif

        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_sel", bus.rom_select, 7);
        chk("rst_acc", dut.acc_q, 0);
        chk("rst_x2", dut.x2_q, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // x = 0: latency and ROM walk.
        run_op(16'sd0, lat, res);
        chk("x0_latency", lat, 9);
        chk("x0_result", res, 1024);
        for (int k = 2; k <= 8; k++) chk("x0_rom_walk", sel_seen[k], 8 - k);

        // x = 32: x2 = 1, each p = -1.
        run_op(16'sd32, lat, res);
        chk("x32_latency", lat, 9);
        chk("x32_result", res, 1023);

        // Start held for 20 edges: two back-to-back operations.
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.x_in = 16'($urandom);
        c0 = dut_done_cnt;
        repeat (20) @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        chk("held_done_pulses", dut_done_cnt - c0, 2);

        // Reset at E+5 aborts.
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.x_in = 16'sd700;
        @(posedge clk);              // E
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);   // E+4
        #1 rst_n = 1'b0;
        @(posedge clk);              // E+5
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_sel", bus.rom_select, 7);
        rst_n = 1'b1;
        c0 = dut_done_cnt;
        repeat (20) @(posedge clk);
        chk("abort_no_done", dut_done_cnt - c0, 0);

        // Extreme operand.
        golden(16'sh7FFF, gx2, gaccs);
        run_op(16'sh7FFF, lat, res);
        chk("max_latency", lat, 9);
        chk("max_result", res, gaccs[7]);

        // Random traffic: start pulses at random, including while busy.
        c0  = m_done_cnt;
        cyc = 0;
        while ((m_done_cnt - c0) < 1000 && cyc < 40000) begin
            @(posedge clk);
            #1 bus.start = ($urandom_range(0, 2) == 0);
            bus.x_in = 16'($urandom);
            cyc++;
        end
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        chk("random_ops_done", ((m_done_cnt - c0) >= 1000) ? 1 : 0, 1);
        chk("done_count_total", dut_done_cnt, m_done_cnt);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
